// File: rtl/fifo_tx_drain_ctrl_if.sv
// Handshake bundle between the FIFO read port, the drain controller and the transmitter.
// The master modport is the controller side; the slave modport is the environment side.
interface fifo_tx_drain_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
);
  logic              i_en;
  logic              i_rempty;
  logic [DATA_W-1:0] i_rdata;
  logic              o_rinc;
  logic [DATA_W-1:0] o_tx_data;
  logic              o_tx_valid;
  logic              i_tx_busy;
  logic              o_busy;
  logic [CNT_W-1:0]  o_word_cnt;
  logic              o_err;

  modport master (
    input  i_en, i_rempty, i_rdata, i_tx_busy,
    output o_rinc, o_tx_data, o_tx_valid, o_busy, o_word_cnt, o_err
  );

  modport slave (
    output i_en, i_rempty, i_rdata, i_tx_busy,
    input  o_rinc, o_tx_data, o_tx_valid, o_busy, o_word_cnt, o_err
  );
endinterface

// File: rtl/fifo_tx_drain_ctrl.sv
// Drains an async FIFO read port into a valid/busy byte-serial transmitter,
// re-pulsing valid on a missed handshake and dropping the word after MAX_RETRY re-pulses.
module fifo_tx_drain_ctrl #(
  parameter int DATA_W    = 8,
  parameter int TIMEOUT   = 16,
  parameter int MAX_RETRY = 3,
  parameter int GAP_CYC   = 2,
  parameter int CNT_W     = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  fifo_tx_drain_ctrl_if.master bus
);

  localparam int TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam int RTY_W = $clog2(MAX_RETRY + 2);
  localparam int GAP_W = $clog2(GAP_CYC + 2);

  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);
  localparam logic [RTY_W-1:0] RTY_MAX   = RTY_W'(MAX_RETRY);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYC);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_HI = 2'd1,
    WAIT_LO = 2'd2,
    GAP     = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              rinc_q, rinc_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [RTY_W-1:0]  retry_q, retry_d;
  logic [GAP_W-1:0]  gap_q, gap_d;

  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    rinc_d    = 1'b0;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    retry_d   = retry_q;
    gap_d     = gap_q;

    case (state_q)
      IDLE: begin
        if (bus.i_en && !bus.i_rempty && !bus.i_tx_busy) begin
          tx_data_d = bus.i_rdata;
          rinc_d    = 1'b1;
          valid_d   = 1'b1;
          retry_d   = '0;
          tmo_d     = '0;
          state_d   = WAIT_HI;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_HI: begin
        // A busy rise wins over a simultaneous timeout expiry.
        if (bus.i_tx_busy) begin
          tmo_d   = '0;
          state_d = WAIT_LO;
        end else if (tmo_q == TMO_LAST) begin
          tmo_d = '0;
          if (retry_q < RTY_MAX) begin
            valid_d = 1'b1;
            retry_d = retry_q + RTY_W'(1);
          end else begin
            err_d   = 1'b1;
            gap_d   = '0;
            state_d = GAP;
          end
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      WAIT_LO: begin
        if (!bus.i_tx_busy) begin
          cnt_d   = cnt_q + CNT_W'(1);
          gap_d   = '0;
          state_d = GAP;
        end else begin
          state_d = WAIT_LO;
        end
      end
      GAP: begin
        // GAP lasts GAP_CYC+1 cycles so a pop lands 3+GAP_CYC cycles after busy falls.
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      tx_data_q <= '0;
      rinc_q    <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      tmo_q     <= '0;
      retry_q   <= '0;
      gap_q     <= '0;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
      rinc_q    <= rinc_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      retry_q   <= retry_d;
      gap_q     <= gap_d;
    end
  end

  assign bus.o_rinc     = rinc_q;
  assign bus.o_tx_data  = tx_data_q;
  assign bus.o_tx_valid = valid_q;
  assign bus.o_busy     = busy_q;
  assign bus.o_word_cnt = cnt_q;
  assign bus.o_err      = err_q;

endmodule

// File: tb/tb_fifo_tx_drain_ctrl.sv
// Directed bench for fifo_tx_drain_ctrl with a FIFO model and a transmitter model
// that can ignore a programmable number of valid pulses. CNT_W=4 exercises the counter wrap.
module tb_fifo_tx_drain_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fifo_tx_drain_ctrl_if #(.DATA_W(8), .CNT_W(4)) bus ();

  fifo_tx_drain_ctrl #(
    .DATA_W(8), .TIMEOUT(16), .MAX_RETRY(3), .GAP_CYC(2), .CNT_W(4)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0] fifo_q[$];
  int         valid_cyc[$];
  logic [7:0] valid_data[$];
  int cyc = 0;
  int rinc_cnt = 0, valid_cnt = 0, err_cnt = 0, err_cyc = 0;
  int ignore = 0, pend = 0, hold = 0;
  int last_fall = 0, min_gap = 1000;
  bit have_fall = 1'b0;

  // FIFO, transmitter and monitor models, updated just after each rising edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (bus.o_rinc) begin
      rinc_cnt++;
      if (have_fall && (cyc - last_fall) < min_gap) min_gap = cyc - last_fall;
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
    end
    if (bus.o_tx_valid) begin
      valid_cnt++;
      valid_cyc.push_back(cyc);
      valid_data.push_back(bus.o_tx_data);
      if (ignore > 0) ignore--;
      else pend = 2;
    end
    if (bus.o_err) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        bus.i_tx_busy = 1'b1;
        hold = 10;
      end
    end else if (hold > 0) begin
      hold--;
      if (hold == 0) begin
        bus.i_tx_busy = 1'b0;
        last_fall = cyc;
        have_fall = 1'b1;
      end
    end
    bus.i_rempty = (fifo_q.size() == 0);
    bus.i_rdata  = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
  end

  task automatic clear_stats();
    rinc_cnt = 0; valid_cnt = 0; err_cnt = 0; err_cyc = 0;
    valid_cyc.delete(); valid_data.delete();
    min_gap = 1000;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    fifo_q.delete();
    pend = 0; hold = 0; ignore = 0;
    bus.i_tx_busy = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_stats();
  endtask

  task automatic wait_idle(input int maxc);
    int quiet = 0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (!bus.o_busy && !bus.i_tx_busy && pend == 0 && hold == 0 && fifo_q.size() == 0) quiet++;
      else quiet = 0;
      if (quiet >= 8) return;
    end
    checks++; errors++;
    $display("FAIL wait_idle: timeout after %0d cycles, o_busy=%0b", maxc, bus.o_busy);
  endtask

  task automatic test_reset();
    bus.i_en = 1'b0;
    bus.i_rempty = 1'b1;
    bus.i_rdata = 8'h00;
    bus.i_tx_busy = 1'b0;
    do_reset();
    checks++; if ({bus.o_rinc, bus.o_tx_valid, bus.o_err} !== 3'b000) begin errors++;
      $display("FAIL reset_pulses: got %b want 000", {bus.o_rinc, bus.o_tx_valid, bus.o_err}); end
    checks++; if (bus.o_tx_data !== 8'h00) begin errors++;
      $display("FAIL reset_data: got %h want 00", bus.o_tx_data); end
    checks++; if (bus.o_busy !== 1'b0) begin errors++;
      $display("FAIL reset_busy: got %b want 0", bus.o_busy); end
    checks++; if (bus.o_word_cnt !== 4'd0) begin errors++;
      $display("FAIL reset_cnt: got %0d want 0", bus.o_word_cnt); end
  endtask

  task automatic test_single();
    clear_stats();
    fifo_q.push_back(8'hA5);
    bus.i_en = 1'b1;
    wait_idle(200);
    checks++; if (rinc_cnt !== 1) begin errors++;
      $display("FAIL single_rinc: got %0d want 1", rinc_cnt); end
    checks++; if (valid_cnt !== 1) begin errors++;
      $display("FAIL single_valid: got %0d want 1", valid_cnt); end
    checks++; if (bus.o_tx_data !== 8'hA5) begin errors++;
      $display("FAIL single_data: got %h want a5", bus.o_tx_data); end
    checks++; if (bus.o_word_cnt !== 4'd1) begin errors++;
      $display("FAIL single_cnt: got %0d want 1", bus.o_word_cnt); end
    checks++; if (err_cnt !== 0) begin errors++;
      $display("FAIL single_err: got %0d want 0", err_cnt); end
  endtask

  task automatic test_back_to_back();
    clear_stats();
    for (int i = 1; i <= 4; i++) fifo_q.push_back(8'(i));
    wait_idle(400);
    checks++; if (rinc_cnt !== 4) begin errors++;
      $display("FAIL b2b_rinc: got %0d want 4", rinc_cnt); end
    checks++; if (bus.o_word_cnt !== 4'd5) begin errors++;
      $display("FAIL b2b_cnt: got %0d want 5", bus.o_word_cnt); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (valid_data.size() <= i || valid_data[i] !== 8'(i + 1)) begin errors++;
        $display("FAIL b2b_order[%0d]: got %h want %h", i,
                 (valid_data.size() > i) ? valid_data[i] : 8'hxx, 8'(i + 1)); end
    end
    checks++; if (min_gap < 5) begin errors++;
      $display("FAIL b2b_gap: got %0d cycles want >= 5", min_gap); end
    checks++; if (bus.o_busy !== 1'b0) begin errors++;
      $display("FAIL b2b_idle: got %b want 0", bus.o_busy); end
  endtask

  task automatic test_retry();
    clear_stats();
    ignore = 1;
    fifo_q.push_back(8'h3C);
    wait_idle(300);
    checks++; if (valid_cnt !== 2) begin errors++;
      $display("FAIL retry_valid: got %0d want 2", valid_cnt); end
    checks++; if (valid_cyc.size() < 2 || valid_cyc[1] - valid_cyc[0] !== 16) begin errors++;
      $display("FAIL retry_spacing: got %0d want 16",
               (valid_cyc.size() >= 2) ? valid_cyc[1] - valid_cyc[0] : -1); end
    checks++; if (rinc_cnt !== 1) begin errors++;
      $display("FAIL retry_rinc: got %0d want 1", rinc_cnt); end
    checks++; if (bus.o_word_cnt !== 4'd6) begin errors++;
      $display("FAIL retry_cnt: got %0d want 6", bus.o_word_cnt); end
  endtask

  task automatic test_drop();
    clear_stats();
    ignore = 4;
    fifo_q.push_back(8'h77);
    fifo_q.push_back(8'h88);
    wait_idle(600);
    checks++; if (valid_cnt !== 5) begin errors++;
      $display("FAIL drop_valid: got %0d want 5", valid_cnt); end
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (valid_cyc.size() < 4 || valid_cyc[i] - valid_cyc[i-1] !== 16) begin errors++;
        $display("FAIL drop_spacing[%0d]: got %0d want 16", i,
                 (valid_cyc.size() >= 4) ? valid_cyc[i] - valid_cyc[i-1] : -1); end
    end
    checks++; if (err_cnt !== 1) begin errors++;
      $display("FAIL drop_err: got %0d cycles want 1", err_cnt); end
    checks++; if (valid_cyc.size() < 4 || err_cyc - valid_cyc[3] !== 16) begin errors++;
      $display("FAIL drop_err_time: got %0d want 16",
               (valid_cyc.size() >= 4) ? err_cyc - valid_cyc[3] : -1); end
    checks++; if (rinc_cnt !== 2) begin errors++;
      $display("FAIL drop_rinc: got %0d want 2", rinc_cnt); end
    checks++; if (valid_data.size() < 5 || valid_data[4] !== 8'h88) begin errors++;
      $display("FAIL drop_next: got %h want 88",
               (valid_data.size() >= 5) ? valid_data[4] : 8'hxx); end
    checks++; if (bus.o_word_cnt !== 4'd7) begin errors++;
      $display("FAIL drop_cnt: got %0d want 7", bus.o_word_cnt); end
  endtask

  task automatic test_enable_gating();
    bit seen = 1'b0;
    clear_stats();
    fifo_q.push_back(8'h11);
    fifo_q.push_back(8'h22);
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (bus.i_tx_busy) seen = 1'b1;
    end
    bus.i_en = 1'b0;
    checks++; if (!seen) begin errors++;
      $display("FAIL gate_busy_wait: got no busy want busy within 100 cycles"); end
    repeat (60) @(negedge clk);
    checks++; if (bus.o_word_cnt !== 4'd8) begin errors++;
      $display("FAIL gate_cnt: got %0d want 8", bus.o_word_cnt); end
    checks++; if (rinc_cnt !== 1) begin errors++;
      $display("FAIL gate_no_pop: got %0d want 1", rinc_cnt); end
    checks++; if (bus.o_busy !== 1'b0) begin errors++;
      $display("FAIL gate_idle: got %b want 0", bus.o_busy); end
    bus.i_en = 1'b1;
    wait_idle(200);
    checks++; if (rinc_cnt !== 2) begin errors++;
      $display("FAIL gate_resume_rinc: got %0d want 2", rinc_cnt); end
    checks++; if (bus.o_word_cnt !== 4'd9) begin errors++;
      $display("FAIL gate_resume_cnt: got %0d want 9", bus.o_word_cnt); end
  endtask

  task automatic test_mid_reset();
    clear_stats();
    ignore = 100;
    fifo_q.push_back(8'h55);
    repeat (8) @(negedge clk);
    checks++; if (!(bus.o_busy && !bus.i_tx_busy)) begin errors++;
      $display("FAIL midrst_pre: got busy=%b tx_busy=%b want 1 0", bus.o_busy, bus.i_tx_busy); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({bus.o_rinc, bus.o_tx_valid, bus.o_busy, bus.o_err} !== 4'b0000) begin errors++;
      $display("FAIL midrst_outputs: got %b want 0000",
               {bus.o_rinc, bus.o_tx_valid, bus.o_busy, bus.o_err}); end
    checks++; if (bus.o_word_cnt !== 4'd0 || bus.o_tx_data !== 8'h00) begin errors++;
      $display("FAIL midrst_regs: got cnt=%0d data=%h want 0 00", bus.o_word_cnt, bus.o_tx_data); end
    rst = 1'b0;
    ignore = 0;
    checks++; if (err_cnt !== 0 || rinc_cnt !== 1) begin errors++;
      $display("FAIL midrst_side: got err=%0d rinc=%0d want 0 1", err_cnt, rinc_cnt); end
    fifo_q.push_back(8'h66);
    wait_idle(200);
    checks++; if (rinc_cnt !== 2 || bus.o_word_cnt !== 4'd1 || err_cnt !== 0) begin errors++;
      $display("FAIL midrst_resume: got rinc=%0d cnt=%0d err=%0d want 2 1 0",
               rinc_cnt, bus.o_word_cnt, err_cnt); end
    checks++; if (bus.o_tx_data !== 8'h66) begin errors++;
      $display("FAIL midrst_data: got %h want 66", bus.o_tx_data); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 17; i++) fifo_q.push_back(8'(8'h40 + i));
    wait_idle(2000);
    checks++; if (rinc_cnt !== 17) begin errors++;
      $display("FAIL wrap_rinc: got %0d want 17", rinc_cnt); end
    checks++; if (bus.o_word_cnt !== 4'd1) begin errors++;
      $display("FAIL wrap_cnt: got %0d want 1", bus.o_word_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_retry();
    test_drop();
    test_enable_gating();
    test_mid_reset();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
